// File: rtl/he_pixel_source_if.sv
// he_pixel_source_if: start, frame-memory read port and pixel stream of the pixel source
interface he_pixel_source_if;
   logic        start;
   logic        mem_rd_en;
   logic [18:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic [7:0]  pixel_value;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        pixel_eol;
   logic        pixel_eof;
   logic        busy;
   logic        frame_done;
   modport master (
      input  start, mem_rdata, pixel_ready,
      output mem_rd_en, mem_addr, pixel_value, pixel_valid, pixel_eol, pixel_eof, busy, frame_done
   );
   modport slave (
      output start, mem_rdata, pixel_ready,
      input  mem_rd_en, mem_addr, pixel_value, pixel_valid, pixel_eol, pixel_eof, busy, frame_done
   );
endinterface

// File: rtl/he_pixel_source.sv
// he_pixel_source: streams one frame from memory in raster order as a ready/valid pixel stream
module he_pixel_source #(
   parameter int IMAGE_WIDTH  = 660,
   parameter int IMAGE_HEIGHT = 440
) (
   input logic               clk,
   input logic               reset,
   he_pixel_source_if.master px
);
   localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam logic [18:0] LAST_ADDR = 19'(NUM_PIXELS - 1);
   localparam logic [18:0] LAST_COL = 19'(IMAGE_WIDTH - 1);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t state, state_nx;
   logic [18:0] rd_addr, rd_col;
   logic [9:0] e0, e1, inc, l0, l1;
   logic [1:0] count;
   logic inflight, in_eol, in_eof, valid, xfer, rd, done;
   // Returning read data counts as the newest buffer entry, so it is visible in the cycle it arrives.
   always_comb begin
      inc = {in_eof, in_eol, px.mem_rdata};
      l0 = count != 2'd0 ? e0 : inc;
      l1 = count == 2'd2 ? e1 : inc;
      valid = count != 2'd0 || inflight;
      xfer = valid && px.pixel_ready;
      rd = state == FETCH && (count + 2'(inflight) < 2'd2 || xfer);
      state_nx = state == IDLE ? (px.start ? FETCH : IDLE) :
                 state == FETCH ? (rd && rd_addr == LAST_ADDR ? DRAIN : FETCH) :
                 (xfer && l0[9] ? IDLE : DRAIN);
   end
   assign px.mem_rd_en = rd;
   assign px.mem_addr = rd ? rd_addr : '0;
   assign px.pixel_valid = valid;
   assign px.pixel_value = valid ? l0[7:0] : '0;
   assign px.pixel_eol = valid && l0[8];
   assign px.pixel_eof = valid && l0[9];
   assign px.busy = state != IDLE;
   assign px.frame_done = done;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         inflight <= 1'b0;
         in_eol <= 1'b0;
         in_eof <= 1'b0;
         rd_addr <= '0;
         rd_col <= '0;
         e0 <= '0;
         e1 <= '0;
         done <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count + 2'(inflight) - 2'(xfer);
         inflight <= rd;
         e0 <= xfer ? l1 : l0;
         e1 <= l1;
         done <= xfer && l0[9];
         if (rd) begin
            in_eol <= rd_col == LAST_COL;
            in_eof <= rd_addr == LAST_ADDR;
            rd_addr <= rd_addr == LAST_ADDR ? '0 : rd_addr + 19'd1;
            rd_col <= rd_col == LAST_COL ? '0 : rd_col + 19'd1;
         end
      end
   end
endmodule

// File: tb/tb_he_pixel_source.sv
// tb_he_pixel_source: scoreboard bench for a 4x2 frame with a memory holding addr*3
module tb_he_pixel_source;
   localparam int W = 4;
   localparam int H = 2;
   localparam int N = W * H;
   logic clk = 1'b0;
   logic reset;
   he_pixel_source_if px();
   he_pixel_source #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (.clk(clk), .reset(reset), .px(px));
   always #5 clk = ~clk;
   always @(posedge clk) if (px.mem_rd_en) px.mem_rdata <= 8'(px.mem_addr * 19'd3);
   logic [9:0] sb[$];
   logic [9:0] got, expv, prev_got;
   logic [18:0] raddr;
   bit xf, rd, empty_pop, stall, prev_stall;
   int n_vec, n_err;
   function automatic logic [9:0] model(input logic [18:0] a);
      int i = int'(a);
      return {i == N - 1, i % W == W - 1, 8'(i * 3)};
   endfunction
   // Drives one cycle of inputs, then samples that cycle: transfers pop the scoreboard, reads push it.
   task automatic tick(input logic rdy, input logic st, input logic rs);
      @(posedge clk);
      #1;
      px.pixel_ready = rdy;
      px.start = st;
      reset = rs;
      @(negedge clk);
      prev_stall = stall;
      prev_got = got;
      got = {px.pixel_eof, px.pixel_eol, px.pixel_value};
      xf = px.pixel_valid && px.pixel_ready;
      stall = px.pixel_valid && !px.pixel_ready;
      rd = px.mem_rd_en;
      raddr = px.mem_addr;
      empty_pop = 1'b0;
      if (xf) begin
         if (sb.size() == 0) empty_pop = 1'b1;
         else expv = sb.pop_front();
      end
      if (rd) sb.push_back(model(raddr));
   endtask
   task automatic test_reset;
      tick(0, 0, 1);
      tick(0, 0, 1);
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if ({px.pixel_valid, px.pixel_eol, px.pixel_eof, px.mem_rd_en, px.busy, px.frame_done, px.pixel_value, px.mem_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b eol=%b eof=%b rd=%b busy=%b done=%b value=%h addr=%h, all required 0",
                     px.pixel_valid, px.pixel_eol, px.pixel_eof, px.mem_rd_en, px.busy, px.frame_done, px.pixel_value, px.mem_addr);
         end
         tick(0, 0, 0);
      end
   endtask
   task automatic test_stream;
      int npx = 0;
      tick(1, 1, 0);
      for (int k = 1; k <= 12; k++) begin
         tick(1, 0, 0);
         n_vec++;
         if (px.busy !== (k <= 9) || px.frame_done !== (k == 10)) begin
            n_err++;
            $display("FAIL stream_busy_done k=%0d: busy=%b done=%b, required busy=%b done=%b", k, px.busy, px.frame_done, k <= 9, k == 10);
         end
         if (k == 1) begin
            n_vec++;
            if (!rd || raddr !== 19'd0) begin
               n_err++;
               $display("FAIL stream_first_read: rd=%b addr=%0d, required rd=1 addr=0", rd, raddr);
            end
         end
         if (!rd) begin
            n_vec++;
            if (raddr !== 19'd0) begin
               n_err++;
               $display("FAIL stream_idle_addr k=%0d: addr=%0d, required 0", k, raddr);
            end
         end
         if (k >= 2 && k <= 9) begin
            n_vec++;
            if (!xf || got[7:0] !== 8'((k - 2) * 3)) begin
               n_err++;
               $display("FAIL stream_pixel k=%0d: xfer=%b value=%0d, required xfer=1 value=%0d", k, xf, got[7:0], (k - 2) * 3);
            end
         end
         if (xf) begin
            npx++;
            n_vec++;
            if (empty_pop || got !== expv) begin
               n_err++;
               $display("FAIL stream_sb k=%0d: got %h, required %h (empty=%b)", k, got, expv, empty_pop);
            end
         end
      end
      n_vec++;
      if (npx != N) begin
         n_err++;
         $display("FAIL stream_count: %0d pixels, required %0d", npx, N);
      end
   endtask
   task automatic test_stall;
      int npx = 0, ndone = 0;
      tick(1, 1, 0);
      for (int k = 1; k <= 40; k++) begin
         tick((k % 3) == 0, 0, 0);
         if (px.frame_done) ndone++;
         n_vec++;
         if (sb.size() > 2) begin
            n_err++;
            $display("FAIL stall_outstanding k=%0d: %0d outstanding, required <= 2", k, sb.size());
         end
         if (prev_stall) begin
            n_vec++;
            if ({px.pixel_valid, got} !== {1'b1, prev_got}) begin
               n_err++;
               $display("FAIL stall_stable k=%0d: valid=%b px=%h, required valid=1 px=%h", k, px.pixel_valid, got, prev_got);
            end
         end
         if (xf) begin
            npx++;
            n_vec++;
            if (empty_pop || got !== expv) begin
               n_err++;
               $display("FAIL stall_sb k=%0d: got %h, required %h (empty=%b)", k, got, expv, empty_pop);
            end
         end
      end
      n_vec++;
      if (npx != N || ndone != 1) begin
         n_err++;
         $display("FAIL stall_count: %0d pixels %0d done, required %0d pixels 1 done", npx, ndone, N);
      end
   endtask
   task automatic test_backpressure;
      int nrd = 0, npx = 0, ndone = 0;
      tick(0, 1, 0);
      for (int k = 1; k <= 20; k++) begin
         tick(0, 0, 0);
         if (rd) begin
            n_vec++;
            if (raddr !== 19'(nrd)) begin
               n_err++;
               $display("FAIL bp_addr k=%0d: addr=%0d, required %0d", k, raddr, nrd);
            end
            nrd++;
         end
      end
      n_vec++;
      if (nrd != 2 || sb.size() != 2) begin
         n_err++;
         $display("FAIL bp_reads: %0d reads %0d outstanding, required 2 and 2", nrd, sb.size());
      end
      for (int k = 1; k <= 15; k++) begin
         tick(1, 0, 0);
         if (px.frame_done) ndone++;
         if (k == 1) begin
            n_vec++;
            if (!rd || raddr !== 19'd2) begin
               n_err++;
               $display("FAIL bp_resume: rd=%b addr=%0d, required rd=1 addr=2", rd, raddr);
            end
         end
         if (xf) begin
            npx++;
            n_vec++;
            if (empty_pop || got !== expv) begin
               n_err++;
               $display("FAIL bp_sb k=%0d: got %h, required %h (empty=%b)", k, got, expv, empty_pop);
            end
         end
      end
      n_vec++;
      if (npx != N || ndone != 1) begin
         n_err++;
         $display("FAIL bp_count: %0d pixels %0d done, required %0d pixels 1 done", npx, ndone, N);
      end
   endtask
   task automatic test_reset_mid;
      int n = 0;
      tick(1, 1, 0);
      for (int k = 1; k <= 8 && n < 3; k++) begin
         tick(1, 0, 0);
         if (xf) n++;
      end
      n_vec++;
      if (n != 3) begin
         n_err++;
         $display("FAIL midrst_setup: %0d transfers, required 3", n);
      end
      tick(1, 0, 1);
      sb.delete();
      tick(1, 0, 0);
      n_vec++;
      if ({px.pixel_valid, px.pixel_eol, px.pixel_eof, px.mem_rd_en, px.busy, px.frame_done, px.pixel_value, px.mem_addr} !== '0) begin
         n_err++;
         $display("FAIL midrst_outputs: valid=%b eol=%b eof=%b rd=%b busy=%b done=%b value=%h addr=%h, all required 0",
                  px.pixel_valid, px.pixel_eol, px.pixel_eof, px.mem_rd_en, px.busy, px.frame_done, px.pixel_value, px.mem_addr);
      end
      for (int k = 0; k < 5; k++) begin
         tick(1, 0, 0);
         n_vec++;
         if (px.frame_done || rd || px.pixel_valid) begin
            n_err++;
            $display("FAIL midrst_quiet k=%0d: done=%b rd=%b valid=%b, required 0 0 0", k, px.frame_done, rd, px.pixel_valid);
         end
      end
      test_stream();
   endtask
   task automatic test_restart_ignored;
      int npx = 0, ndone = 0;
      tick(1, 1, 0);
      for (int k = 1; k <= 16; k++) begin
         tick(1, k == 3 || k == 6, 0);
         if (px.frame_done) ndone++;
         if (k > 10) begin
            n_vec++;
            if (rd || px.busy) begin
               n_err++;
               $display("FAIL restart_idle k=%0d: rd=%b busy=%b, required 0 0", k, rd, px.busy);
            end
         end
         if (xf) begin
            npx++;
            n_vec++;
            if (empty_pop || got !== expv) begin
               n_err++;
               $display("FAIL restart_sb k=%0d: got %h, required %h (empty=%b)", k, got, expv, empty_pop);
            end
         end
      end
      n_vec++;
      if (npx != N || ndone != 1) begin
         n_err++;
         $display("FAIL restart_count: %0d pixels %0d done, required %0d pixels 1 done", npx, ndone, N);
      end
   endtask
   task automatic test_back_to_back;
      int npx = 0, ndone = 0;
      tick(1, 1, 0);
      for (int k = 1; k <= 22; k++) begin
         tick(1, k == 10, 0);
         if (px.frame_done) ndone++;
         if (k == 10 || k == 20) begin
            n_vec++;
            if (px.frame_done !== 1'b1 || px.busy !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_done k=%0d: done=%b busy=%b, required 1 0", k, px.frame_done, px.busy);
            end
         end
         if (k == 11) begin
            n_vec++;
            if (!rd || raddr !== 19'd0 || !px.busy) begin
               n_err++;
               $display("FAIL b2b_first_read: rd=%b addr=%0d busy=%b, required 1 0 1", rd, raddr, px.busy);
            end
         end
         if (xf) begin
            npx++;
            n_vec++;
            if (empty_pop || got !== expv) begin
               n_err++;
               $display("FAIL b2b_sb k=%0d: got %h, required %h (empty=%b)", k, got, expv, empty_pop);
            end
         end
      end
      n_vec++;
      if (npx != 2 * N || ndone != 2) begin
         n_err++;
         $display("FAIL b2b_count: %0d pixels %0d done, required %0d pixels 2 done", npx, ndone, 2 * N);
      end
   endtask
   initial begin
      reset = 1'b1;
      px.start = 1'b0;
      px.pixel_ready = 1'b0;
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_stream();
      tick(1, 0, 0);
      test_stall();
      tick(1, 0, 0);
      test_backpressure();
      tick(1, 0, 0);
      test_reset_mid();
      tick(1, 0, 0);
      test_restart_ignored();
      tick(1, 0, 0);
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/he_pixel_source.md
HE_PIXEL_SOURCE -- requirements
Module: he_pixel_source

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 660, pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 440, lines per frame.
REQ-003 SHALL derive NUM_PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT; the address and pixel counters SHALL be 19 bits wide.
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to stream one frame.
REQ-007 SHALL have port mem_rd_en  output  1  frame-memory read strobe.
REQ-008 SHALL have port mem_addr  output  19  frame-memory read address, raster order.
REQ-009 SHALL have port mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-010 SHALL have port pixel_value  output  8  pixel toward the equalizer.
REQ-011 SHALL have port pixel_valid  output  1  pixel_value holds a valid pixel.
REQ-012 SHALL have port pixel_ready  input  1  sink accepts a pixel; a transfer is valid && ready on a rising edge.
REQ-013 SHALL have port pixel_eol  output  1  current pixel is in column IMAGE_WIDTH-1.
REQ-014 SHALL have port pixel_eof  output  1  current pixel is pixel NUM_PIXELS-1.
REQ-015 SHALL have port busy  output  1  high from the cycle after an accepted start until frame_done.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last transfer.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, as follows.
- IDLE: start=1 goes to FETCH.
- FETCH: goes to DRAIN once read NUM_PIXELS-1 has issued.
- DRAIN: goes to IDLE on the transfer of the last pixel.
REQ-018 SHALL ignore start when not in IDLE.
REQ-019 SHALL hold a 2-entry pixel buffer, with pixel_valid equal to buffer non-empty and pixel_value/eol/eof taken from the buffer head.
REQ-020 SHALL issue a read in FETCH only when (stored entries + in-flight read) < 2, or when that sum is 2 and a transfer occurs in the same cycle.
REQ-021 SHALL increment mem_addr by 1 per issued read, starting at 0 and ending at NUM_PIXELS-1, with no read ever beyond NUM_PIXELS-1.
REQ-022 SHALL write mem_rdata into the buffer in the cycle after its read, together with eol/eof flags computed from that read's address.
REQ-023 SHALL meet the following timing when start is sampled at edge t and pixel_ready stays 1.
- First mem_rd_en (addr 0) is in cycle t+1.
- pixel 0 is valid in cycle t+2.
- Throughput is 1 pixel/cycle.
- The last transfer occurs at edge t+1+NUM_PIXELS.
- frame_done is high for the following cycle.
REQ-024 SHALL keep pixel_value, pixel_eol and pixel_eof stable while pixel_valid=1 and pixel_ready=0.
REQ-025 SHALL lose no pixel and duplicate no pixel under any pixel_ready pattern, and SHALL issue no read while the buffer is full with no transfer.
REQ-026 SHALL handle a simultaneous buffer write and transfer with no change in occupancy and correct order.
REQ-027 SHALL generate pixel_eol from a column counter that wraps from IMAGE_WIDTH-1 to 0.
REQ-028 SHALL assert pixel_eol and pixel_eof together on the final pixel.
REQ-029 SHALL drop busy in the same cycle frame_done pulses.
REQ-030 SHALL accept a new start in the cycle frame_done is high, because the state is then IDLE.
REQ-031 SHALL drive mem_addr to 0 whenever mem_rd_en=0.

Reset
REQ-032 SHALL, on reset=1 at a rising edge, set the following in the next cycle.
- State is IDLE.
- The buffer is empty.
- All counters are 0.
- pixel_valid, pixel_eol, pixel_eof, mem_rd_en, busy and frame_done are 0.
- pixel_value and mem_addr are 0.
REQ-033 SHALL, on reset mid-frame, discard any in-flight read data, produce no frame_done, and restart only on a new start.
REQ-034 SHALL give reset priority over start in the same cycle.

Verification
REQ-035 SHALL cover: WIDTH=4, HEIGHT=2, memory holds addr*3, ready=1, start at t -> pixels 0,3,...,21 at t+2..t+9, eol on values 9 and 21, eof on 21, frame_done at t+10.
REQ-036 SHALL cover: same setup with ready toggled 1,0,0,1,0,... -> the same 8 pixels in order, outputs stable while stalled, and never more than 2 outstanding reads plus stored entries.
REQ-037 SHALL cover: ready=0 for 20 cycles after start -> exactly 2 reads (addr 0,1), then no mem_rd_en until ready rises.
REQ-038 SHALL cover: reset after 3 transfers -> all outputs 0 next cycle, and a new start streams from addr 0 with the full 8 pixels.
REQ-039 SHALL cover: start re-pulsed while busy -> ignored, and exactly one frame_done.
REQ-040 SHALL cover: start asserted in the frame_done cycle -> a second frame begins, and first mem_rd_en addr 0 appears one cycle later.
